// File: rtl/conv_fc_engine_param_if.sv
// Bus interface for conv_fc_engine_param: request, operand and result signals.
// The master drives start and the operands; the slave (engine) drives the results.
interface conv_fc_engine_param_if #(
    parameter int IMG_N = 4,
    parameter int K     = 3,
    parameter int W     = 16
);
    localparam int OUT_N = IMG_N - K + 1;
    localparam int NFC   = OUT_N * OUT_N;

    // Handshake: start is a request sampled only while the engine is idle; the
    // accepting edge snapshots every operand. busy is high from the cycle after
    // that edge until done. done is a one-cycle pulse marking output_value,
    // conv_map and sat_flag valid; they hold until the next accepted start or reset.
    // A start seen while busy is dropped, not queued.
    logic                start;
    logic signed [W-1:0] input_feature  [IMG_N][IMG_N];
    logic signed [W-1:0] kernel_weights [K][K];
    logic signed [W-1:0] fc_weights     [NFC];
    logic signed [W-1:0] fc_bias;
    logic                busy;
    logic                done;
    logic signed [W-1:0] output_value;
    logic signed [W-1:0] conv_map       [NFC];
    logic                sat_flag;
    logic [2:0]          fsm_state;

    modport master (
        output start, input_feature, kernel_weights, fc_weights, fc_bias,
        input  busy, done, output_value, conv_map, sat_flag, fsm_state
    );

    modport slave (
        input  start, input_feature, kernel_weights, fc_weights, fc_bias,
        output busy, done, output_value, conv_map, sat_flag, fsm_state
    );
endinterface

// File: rtl/conv_fc_engine_param.sv
// conv_fc_engine_param: KxK valid conv over an IMG_N x IMG_N fixed-point image,
// followed by a single-output FC layer, on one time-shared MAC.
// Optional feature macro: CONV_RELU_EN (ReLU on conv results; saturation is
// still detected before the ReLU). Default build: signed conv results.
module conv_fc_engine_param #(
    parameter int IMG_N = 4,
    parameter int K     = 3,
    parameter int W     = 16,
    parameter int FRAC  = 8,
    parameter int ACC_W = 40
) (
    input  logic clk,
    input  logic rst,
    conv_fc_engine_param_if.slave bus_if
);
    localparam int OUT_N = IMG_N - K + 1;
    localparam int NFC   = OUT_N * OUT_N;
    localparam int IIW   = (IMG_N > 1) ? $clog2(IMG_N) : 1;
    localparam int KIW   = (K > 1)     ? $clog2(K)     : 1;
    localparam int OIW   = (OUT_N > 1) ? $clog2(OUT_N) : 1;
    localparam int FIW   = (NFC > 1)   ? $clog2(NFC)   : 1;

    localparam logic signed [ACC_W-1:0] MAXV = {{(ACC_W-W+1){1'b0}}, {(W-1){1'b1}}};
    localparam logic signed [ACC_W-1:0] MINV = {{(ACC_W-W+1){1'b1}}, {(W-1){1'b0}}};
    localparam logic signed [W-1:0]     SMAX = {1'b0, {(W-1){1'b1}}};
    localparam logic signed [W-1:0]     SMIN = {1'b1, {(W-1){1'b0}}};

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_CONV    = 3'd1,
        S_CONV_WB = 3'd2,
        S_FC      = 3'd3,
        S_FC_WB   = 3'd4,
        S_DONE    = 3'd5
    } state_t;

    state_t              state_q, state_d;
    logic signed [W-1:0] img_q  [IMG_N][IMG_N];
    logic signed [W-1:0] ker_q  [K][K];
    logic signed [W-1:0] fcw_q  [NFC];
    logic signed [W-1:0] bias_q;
    logic signed [W-1:0] conv_q [NFC];
    logic signed [W-1:0] conv_d [NFC];
    logic [KIW-1:0]      ki_q, ki_d, kj_q, kj_d;
    logic [OIW-1:0]      r_q, r_d, c_q, c_d;
    logic [FIW-1:0]      fi_q, fi_d;
    logic signed [ACC_W-1:0] acc_q, acc_d;
    logic signed [W-1:0] out_q, out_d;
    logic                sat_q, sat_d, busy_q, busy_d, done_q, done_d;

    logic signed [W-1:0]     mac_a, mac_b, sat_res, conv_res;
    logic signed [2*W-1:0]   prod;
    logic signed [ACC_W-1:0] shifted;
    logic                    clamp, last_tap, last_pix, last_fc;
    logic [IIW-1:0]          ir, ic;
    logic [FIW-1:0]          pix;

    assign ir       = IIW'(r_q) + IIW'(ki_q);
    assign ic       = IIW'(c_q) + IIW'(kj_q);
    assign pix      = FIW'(r_q) * FIW'(OUT_N) + FIW'(c_q);
    assign last_tap = (ki_q == KIW'(K-1)) && (kj_q == KIW'(K-1));
    assign last_pix = (r_q == OIW'(OUT_N-1)) && (c_q == OIW'(OUT_N-1));
    assign last_fc  = (fi_q == FIW'(NFC-1));
    assign prod     = mac_a * mac_b;
    assign shifted  = acc_q >>> FRAC;

    // Saturate the scaled accumulator to the data width and flag any clamping
    always_comb begin
        clamp   = 1'b0;
        sat_res = shifted[W-1:0];
        if (shifted > MAXV) begin
            sat_res = SMAX;
            clamp   = 1'b1;
        end else if (shifted < MINV) begin
            sat_res = SMIN;
            clamp   = 1'b1;
        end
    end

`ifdef CONV_RELU_EN
    assign conv_res = sat_res[W-1] ? '0 : sat_res;
`else
    assign conv_res = sat_res;
`endif

    // State register
    always_ff @(posedge clk) begin
        if (!rst) state_q <= S_IDLE;
        else      state_q <= state_d;
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:    if (bus_if.start) state_d = S_CONV;
            S_CONV:    if (last_tap) state_d = S_CONV_WB;
            S_CONV_WB: state_d = last_pix ? S_FC : S_CONV;
            S_FC:      if (last_fc) state_d = S_FC_WB;
            S_FC_WB:   state_d = S_DONE;
            S_DONE:    state_d = S_IDLE;
            default:   state_d = S_IDLE;
        endcase
    end

    // Output/datapath logic: MAC operand select, counters, write-back, flags
    always_comb begin
        acc_d  = acc_q;
        ki_d   = ki_q;
        kj_d   = kj_q;
        r_d    = r_q;
        c_d    = c_q;
        fi_d   = fi_q;
        conv_d = conv_q;
        out_d  = out_q;
        sat_d  = sat_q;
        busy_d = busy_q;
        done_d = 1'b0;
        mac_a  = '0;
        mac_b  = '0;
        case (state_q)
            S_IDLE: begin
                if (bus_if.start) begin
                    acc_d  = '0;
                    ki_d   = '0;
                    kj_d   = '0;
                    r_d    = '0;
                    c_d    = '0;
                    fi_d   = '0;
                    sat_d  = 1'b0;
                    busy_d = 1'b1;
                end
            end
            S_CONV: begin
                mac_a = img_q[ir][ic];
                mac_b = ker_q[ki_q][kj_q];
                acc_d = acc_q + ACC_W'(prod);
                if (kj_q == KIW'(K-1)) begin
                    kj_d = '0;
                    ki_d = last_tap ? '0 : ki_q + KIW'(1);
                end else begin
                    kj_d = kj_q + KIW'(1);
                end
            end
            S_CONV_WB: begin
                conv_d[pix] = conv_res;
                sat_d       = sat_q | clamp;
                fi_d        = '0;
                if (last_pix) begin
                    r_d   = '0;
                    c_d   = '0;
                    acc_d = ACC_W'(bias_q) <<< FRAC;
                end else begin
                    acc_d = '0;
                    if (c_q == OIW'(OUT_N-1)) begin
                        c_d = '0;
                        r_d = r_q + OIW'(1);
                    end else begin
                        c_d = c_q + OIW'(1);
                    end
                end
            end
            S_FC: begin
                mac_a = conv_q[fi_q];
                mac_b = fcw_q[fi_q];
                acc_d = acc_q + ACC_W'(prod);
                fi_d  = last_fc ? '0 : fi_q + FIW'(1);
            end
            S_FC_WB: begin
                out_d = sat_res;
                sat_d = sat_q | clamp;
            end
            S_DONE: begin
                done_d = 1'b1;
                busy_d = 1'b0;
            end
            default: ;
        endcase
    end

    // Datapath and result registers
    always_ff @(posedge clk) begin
        if (!rst) begin
            acc_q  <= '0;
            ki_q   <= '0;
            kj_q   <= '0;
            r_q    <= '0;
            c_q    <= '0;
            fi_q   <= '0;
            out_q  <= '0;
            sat_q  <= 1'b0;
            busy_q <= 1'b0;
            done_q <= 1'b0;
            for (int i = 0; i < NFC; i++) conv_q[i] <= '0;
        end else begin
            acc_q  <= acc_d;
            ki_q   <= ki_d;
            kj_q   <= kj_d;
            r_q    <= r_d;
            c_q    <= c_d;
            fi_q   <= fi_d;
            out_q  <= out_d;
            sat_q  <= sat_d;
            busy_q <= busy_d;
            done_q <= done_d;
            conv_q <= conv_d;
        end
    end

    // Operand snapshot on the accepting edge; later input changes do not affect the run
    always_ff @(posedge clk) begin
        if (rst && state_q == S_IDLE && bus_if.start) begin
            img_q  <= bus_if.input_feature;
            ker_q  <= bus_if.kernel_weights;
            fcw_q  <= bus_if.fc_weights;
            bias_q <= bus_if.fc_bias;
        end
    end

    assign bus_if.busy         = busy_q;
    assign bus_if.done         = done_q;
    assign bus_if.output_value = out_q;
    assign bus_if.conv_map     = conv_q;
    assign bus_if.sat_flag     = sat_q;
    assign bus_if.fsm_state    = state_q;
endmodule

// File: tb/tb_conv_fc_engine_param.sv
// Testbench for conv_fc_engine_param: directed and randomized runs checked
// against an arithmetic model of the conv + FC forward pass.
module tb_conv_fc_engine_param;
    localparam int IMG_N = 4;
    localparam int K     = 3;
    localparam int W     = 16;
    localparam int FRAC  = 8;
    localparam int ACC_W = 40;
    localparam int OUT_N = IMG_N - K + 1;
    localparam int NFC   = OUT_N * OUT_N;
    localparam int LAT   = NFC * (K*K + 1) + NFC + 2;
    localparam longint SMAX = (longint'(1) <<< (W-1)) - 1;
    localparam longint SMIN = -(longint'(1) <<< (W-1));

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst;
    int   cyc = 0;
    int   start_cyc = 0;
    int   tests_run = 0;
    int   tests_failed = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    conv_fc_engine_param_if #(.IMG_N(IMG_N), .K(K), .W(W)) bus ();

    conv_fc_engine_param #(
        .IMG_N(IMG_N), .K(K), .W(W), .FRAC(FRAC), .ACC_W(ACC_W)
    ) dut (
        .clk    (clk),
        .rst    (rst),
        .bus_if (bus)
    );

    // ---------------- scoreboard ----------------
    logic [W-1:0] exp_q[$];
    logic [W-1:0] exp_map_q[$];
    logic         exp_sat_q[$];

    task automatic check(input string name, input logic signed [63:0] act, input logic signed [63:0] want);
        tests_run++;
        if (act !== want) begin
            tests_failed++;
            $display("FAIL %s: got %0d, expected %0d", name, act, want);
        end
    endtask

    task automatic sat_m(input longint v, output longint r, output bit clamped);
        clamped = 1'b0;
        r = v;
        if (v > SMAX) begin r = SMAX; clamped = 1'b1; end
        else if (v < SMIN) begin r = SMIN; clamped = 1'b1; end
    endtask

    // Model: the forward pass computed directly from the current operands
    task automatic build_expected();
        longint acc, v;
        longint map [NFC];
        bit     c, any;
        any = 1'b0;
        for (int r = 0; r < OUT_N; r++) begin
            for (int cc = 0; cc < OUT_N; cc++) begin
                acc = 0;
                for (int ki = 0; ki < K; ki++)
                    for (int kj = 0; kj < K; kj++)
                        acc += longint'(bus.input_feature[r+ki][cc+kj]) * longint'(bus.kernel_weights[ki][kj]);
                sat_m(acc >>> FRAC, v, c);
                any |= c;
`ifdef CONV_RELU_EN
                if (v < 0) v = 0;
`endif
                map[r*OUT_N + cc] = v;
                exp_map_q.push_back(v[W-1:0]);
            end
        end
        acc = longint'(bus.fc_bias) <<< FRAC;
        for (int i = 0; i < NFC; i++) acc += map[i] * longint'(bus.fc_weights[i]);
        sat_m(acc >>> FRAC, v, c);
        any |= c;
        exp_q.push_back(v[W-1:0]);
        exp_sat_q.push_back(any);
    endtask

    // Compare process: every done pulse is checked against the oldest expectation
    always @(negedge clk) begin
        if (rst === 1'b1 && bus.done === 1'b1) begin
            if (exp_q.size() == 0) begin
                check("unexpected_done", 1, 0);
            end else begin
                check("latency", cyc - start_cyc, LAT);
                check("output_value", $signed(bus.output_value), $signed(exp_q.pop_front()));
                check("sat_flag", bus.sat_flag, exp_sat_q.pop_front());
                for (int i = 0; i < NFC; i++)
                    check($sformatf("conv_map[%0d]", i), $signed(bus.conv_map[i]), $signed(exp_map_q.pop_front()));
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic set_inputs(input int img, input int ker, input int fcw, input int bias);
        for (int i = 0; i < IMG_N; i++)
            for (int j = 0; j < IMG_N; j++) bus.input_feature[i][j] = W'(img);
        for (int i = 0; i < K; i++)
            for (int j = 0; j < K; j++) bus.kernel_weights[i][j] = W'(ker);
        for (int i = 0; i < NFC; i++) bus.fc_weights[i] = W'(fcw);
        bus.fc_bias = W'(bias);
    endtask

    function automatic logic [W-1:0] rnd_val(input bit wide);
        if (wide) return W'($urandom);
        return W'(int'($urandom_range(1023)) - 512);
    endfunction

    task automatic random_inputs(input bit wide);
        for (int i = 0; i < IMG_N; i++)
            for (int j = 0; j < IMG_N; j++) bus.input_feature[i][j] = rnd_val(wide);
        for (int i = 0; i < K; i++)
            for (int j = 0; j < K; j++) bus.kernel_weights[i][j] = rnd_val(wide);
        for (int i = 0; i < NFC; i++) bus.fc_weights[i] = rnd_val(wide);
        bus.fc_bias = rnd_val(wide);
    endtask

    task automatic run_one(input bit scramble);
        build_expected();
        @(negedge clk);
        bus.start = 1'b1;
        @(posedge clk);
        #1;
        start_cyc = cyc;
        bus.start = 1'b0;
        check("busy_after_start", bus.busy, 1);
        if (scramble) begin
            @(posedge clk);
            #1;
            random_inputs(1'b1);
        end
        for (int n = 0; n < LAT + 20 && exp_q.size() != 0; n++) begin
            @(posedge clk);
            #2;
        end
        if (exp_q.size() != 0) begin
            check("done_timeout", 0, 1);
            exp_q.delete();
            exp_map_q.delete();
            exp_sat_q.delete();
        end
        check("busy_after_done", bus.busy, 0);
    endtask

    task automatic check_cleared();
        check("rst_busy", bus.busy, 0);
        check("rst_done", bus.done, 0);
        check("rst_output", $signed(bus.output_value), 0);
        check("rst_sat", bus.sat_flag, 0);
        for (int i = 0; i < NFC; i++) check($sformatf("rst_conv_map[%0d]", i), $signed(bus.conv_map[i]), 0);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        rst = 1'b0;
        bus.start = 1'b0;
        set_inputs(0, 0, 0, 0);
        repeat (3) @(posedge clk);
        #1;
        check_cleared();
        rst = 1'b1;
        repeat (2) @(posedge clk);

        // Nominal: 9*256*64>>8 = 576 per pixel, 4*576*128>>8 = 1152
        set_inputs(256, 64, 128, 0);
        run_one(1'b0);
        check("lit_conv0", $signed(bus.conv_map[0]), 576);
        check("lit_out_nominal", $signed(bus.output_value), 1152);
        check("lit_sat_nominal", bus.sat_flag, 0);

        // Bias 256 adds 256 to the output; inputs scrambled after the start edge
        set_inputs(256, 64, 128, 256);
        run_one(1'b1);
        check("lit_out_bias", $signed(bus.output_value), 1408);

        // Negative kernel
        set_inputs(256, -64, 128, 0);
        run_one(1'b0);
`ifdef CONV_RELU_EN
        check("lit_conv_neg", $signed(bus.conv_map[3]), 0);
        check("lit_out_neg", $signed(bus.output_value), 0);
`else
        check("lit_conv_neg", $signed(bus.conv_map[3]), -576);
        check("lit_out_neg", $signed(bus.output_value), -1152);
`endif

        // Saturation in both stages
        set_inputs(32767, 32767, 128, 0);
        run_one(1'b0);
        check("lit_conv_sat", $signed(bus.conv_map[1]), 32767);
        check("lit_out_sat", $signed(bus.output_value), 32767);
        check("lit_sat_flag", bus.sat_flag, 1);

        // Start pulsed mid-run is ignored, then reset aborts the run
        set_inputs(256, 64, 128, 0);
        @(negedge clk);
        bus.start = 1'b1;
        @(posedge clk);
        #1;
        start_cyc = cyc;
        bus.start = 1'b0;
        repeat (9) @(posedge clk);
        #1;
        bus.start = 1'b1;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        repeat (9) @(posedge clk);
        #1;
        rst = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b1;
        check_cleared();
        repeat (LAT + 10) @(posedge clk);
        check("no_run_after_reset", bus.busy, 0);
        run_one(1'b0);
        check("lit_out_after_reset", $signed(bus.output_value), 1152);

        // Randomized runs: narrow values plus occasional full-range saturating ones
        for (int t = 0; t < 16; t++) begin
            random_inputs(t % 4 == 3);
            run_one(t % 5 == 2);
        end

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end
endmodule
